// File: rtl/col_parity_theta.sv
// Column-parity / theta-effect engine: fetches 64 slices from the slice reader,
// buffers each slice's 5-bit column parity, then streams C and D per slice.
module col_parity_theta #(
   parameter int unsigned N     = 25,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned ZW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          ld,
   output logic [ZW-1:0] line_number,
   input  logic [N-1:0]  pin,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [4:0]    d_out,
   output logic [4:0]    c_out,
   output logic [ZW-1:0] out_z,
   output logic          busy,
   output logic          done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_CAP  = 3'd3;
   localparam logic [2:0] S_EMIT = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam logic [ZW-1:0] Z_LAST = ZW'(DEPTH - 1);

   logic [2:0]    state_q, state_d;
   logic [ZW-1:0] z_q, z_d;
   logic          ld_q, ld_d;
   logic [ZW-1:0] line_q, line_d;
   logic          valid_q, valid_d;
   logic [4:0]    d_q, d_d;
   logic [4:0]    c_q, c_d;
   logic [ZW-1:0] oz_q, oz_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [4:0]    cbuf_q [DEPTH];
   logic          wr_en_c;
   logic [4:0]    par_c;
   logic [ZW-1:0] zp_c;
   logic [4:0]    cur_c, prv_c;

   // Column parity: XOR of the five rows, bit x of each row is pin[5*y+x].
   assign par_c = pin[4:0] ^ pin[9:5] ^ pin[14:10] ^ pin[19:15] ^ pin[24:20];

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      wr_en_c = 1'b0;
      ld_d    = 1'b0;
      line_d  = line_q;
      valid_d = 1'b0;
      d_d     = d_q;
      c_d     = c_q;
      oz_d    = oz_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_REQ;
               z_d     = '0;
               busy_d  = 1'b1;
            end
         end
         S_REQ:  state_d = S_WAIT;
         S_WAIT: state_d = S_CAP;
         S_CAP: begin
            wr_en_c = 1'b1;
            if (z_q == Z_LAST) begin
               z_d     = '0;
               state_d = S_EMIT;
            end else begin
               z_d     = z_q + ZW'(1);
               state_d = S_REQ;
            end
         end
         S_EMIT: begin
            if (out_ready) begin
               if (z_q == Z_LAST) state_d = S_DONE;
               else               z_d     = z_q + ZW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Buffer reads bypass the entry being written on the CAP->EMIT edge.
      zp_c  = z_d - ZW'(1);
      cur_c = cbuf_q[z_d];
      prv_c = cbuf_q[zp_c];
      if (wr_en_c && (z_d == z_q))  cur_c = par_c;
      if (wr_en_c && (zp_c == z_q)) prv_c = par_c;

      if (state_d == S_REQ) begin
         ld_d   = 1'b1;
         line_d = z_d + ZW'(1);
      end
      if (state_d == S_EMIT) begin
         valid_d = 1'b1;
         oz_d    = z_d;
         c_d     = cur_c;
         d_d     = {cur_c[3:0], cur_c[4]} ^ {prv_c[0], prv_c[4:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         z_q     <= '0;
         ld_q    <= 1'b0;
         line_q  <= '0;
         valid_q <= 1'b0;
         d_q     <= '0;
         c_q     <= '0;
         oz_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         ld_q    <= ld_d;
         line_q  <= line_d;
         valid_q <= valid_d;
         d_q     <= d_d;
         c_q     <= c_d;
         oz_q    <= oz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Parity buffer is fully rewritten during every fetch phase, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_c) cbuf_q[z_q] <= par_c;
   end

   assign ld          = ld_q;
   assign line_number = line_q;
   assign out_valid   = valid_q;
   assign d_out       = d_q;
   assign c_out       = c_q;
   assign out_z       = oz_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_col_parity_theta.sv
// Directed bench for col_parity_theta with a behavioural slice reader.
module tb_col_parity_theta;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ld;
   logic [5:0]  line_number;
   logic [24:0] pin;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  d_out;
   logic [4:0]  c_out;
   logic [5:0]  out_z;
   logic        busy;
   logic        done;

   logic [24:0] mem [64];
   logic [4:0]  obs_c [64];
   logic [4:0]  obs_d [64];
   int          n_tests = 0;
   int          n_fail  = 0;

   col_parity_theta dut (
      .clk(clk), .rst(rst), .start(start), .ld(ld), .line_number(line_number),
      .pin(pin), .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
      .c_out(c_out), .out_z(out_z), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Slice reader: registered output, 1-based line numbers (line 64 wraps to 0).
   always @(posedge clk) if (ld) pin <= mem[6'(line_number - 6'd1)];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] mc(input int z);
      logic [4:0]  r;
      logic [24:0] s;
      r = '0;
      s = mem[z];
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++) r[x] = r[x] ^ s[5*y + x];
      return r;
   endfunction

   function automatic logic [4:0] md(input int z);
      logic [4:0] r, a, b;
      a = mc(z);
      b = mc((z + 63) % 64);
      for (int x = 0; x < 5; x++) r[x] = a[(x + 4) % 5] ^ b[(x + 1) % 5];
      return r;
   endfunction

   task automatic fill(input int mode);
      for (int z = 0; z < 64; z++) mem[z] = (mode == 1) ? 25'($urandom) : 25'd0;
   endtask

   task automatic run_full(input bit rnd, input bit glitch);
      int got, busy_cyc, done_cnt, cyc, stall_bad, dup, rerun;
      bit stalled;
      logic [15:0] held;
      got = 0; busy_cyc = 0; done_cnt = 0; cyc = 0; stall_bad = 0; dup = 0; rerun = 0;
      stalled = 1'b0; held = '0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      forever begin
         if (busy) busy_cyc++;
         if (done) done_cnt++;
         if (cyc == 0) chk("first_req", 32'({ld, line_number}), 32'({1'b1, 6'd1}));
         if (glitch && cyc == 50) start = 1'b1;
         else if (glitch && got == 64 && busy && !out_valid) start = 1'b1;
         else start = 1'b0;
         if (stalled && (!out_valid || {out_z, c_out, d_out} !== held)) stall_bad++;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = 1'b0;
         if (out_valid) begin
            if (got >= 64) dup++;
            else if (out_ready) begin
               chk("emit", 32'({out_z, c_out, d_out}), 32'({6'(got), mc(got), md(got)}));
               obs_c[got] = c_out;
               obs_d[got] = d_out;
               got++;
            end else begin
               stalled = 1'b1;
               held = {out_z, c_out, d_out};
            end
         end
         if (!busy && got == 64) break;
         if (cyc >= 3000) break;
         @(negedge clk); cyc++;
      end
      start = 1'b0;
      chk("timeout", 32'(cyc < 3000), 32'd1);
      chk("outputs_seen", 32'(got), 32'd64);
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("dup_outputs", 32'(dup), 32'd0);
      if (rnd) chk("stall_stable", 32'(stall_bad), 32'd0);
      else     chk("busy_cycles", 32'(busy_cyc), 32'd257);
      @(negedge clk);
      chk("done_drop", 32'({done, busy, out_valid}), 32'd0);
      if (glitch) begin
         for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy || out_valid) rerun++;
         end
         chk("no_rerun", 32'(rerun), 32'd0);
      end
   endtask

   task automatic reset_mid(input bit emit_phase);
      int i;
      fill(1);
      out_ready = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (i = 0; i < 600; i++) begin
         if (!emit_phase && ld && line_number == 6'd21) break;
         if (emit_phase && out_valid && out_z == 6'd30) break;
         @(negedge clk);
      end
      chk(emit_phase ? "reach_z30" : "reach_z20", 32'(i < 600), 32'd1);
      #2 rst = 1'b1;
      #1 chk(emit_phase ? "rst_emit" : "rst_fetch",
             32'({ld, line_number, out_valid, d_out, c_out, out_z, busy, done}), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      chk("idle_after_rst", 32'({busy, ld, out_valid}), 32'd0);
      run_full(1'b0, 1'b0);
   endtask

   initial begin
      logic [4:0] acc;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      fill(0);
      repeat (2) @(negedge clk);
      chk("reset_vals", 32'({ld, line_number, out_valid, d_out, c_out, out_z, busy, done}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle", 32'({busy, ld}), 32'd0);

      // All-zero state.
      run_full(1'b0, 1'b0);
      acc = '0;
      for (int z = 0; z < 64; z++) acc = acc | obs_c[z] | obs_d[z];
      chk("zero_all", 32'(acc), 32'd0);

      // Single bit at z=5, x=0, y=0.
      fill(0); mem[5] = 25'h0000001;
      run_full(1'b0, 1'b0);
      chk("z5_c", 32'(obs_c[5]), 32'b00001);
      chk("z5_d", 32'(obs_d[5]), 32'b00010);
      chk("z6_d", 32'(obs_d[6]), 32'b10000);
      chk("z4_d", 32'(obs_d[4]), 32'd0);

      // Wrap across z=63 -> z=0.
      fill(0); mem[63] = 25'h0000001;
      run_full(1'b0, 1'b0);
      chk("wrap_z63_d", 32'(obs_d[63]), 32'b00010);
      chk("wrap_z0_d", 32'(obs_d[0]), 32'b10000);
      chk("wrap_z63_c", 32'(obs_c[63]), 32'b00001);

      // Two bits in the same column cancel.
      fill(0); mem[10] = 25'h0000021;
      run_full(1'b0, 1'b0);
      acc = '0;
      for (int z = 0; z < 64; z++) acc = acc | obs_c[z] | obs_d[z];
      chk("cancel_all", 32'(acc), 32'd0);

      // Random state with random backpressure.
      fill(1);
      run_full(1'b1, 1'b0);
      fill(1);
      run_full(1'b1, 1'b0);

      // Reset mid-fetch and mid-emit, then full passes.
      reset_mid(1'b0);
      reset_mid(1'b1);

      // Start pulses while busy and during DONE are ignored.
      fill(1);
      run_full(1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/col_parity_theta.md
Name: col_parity_theta

Overview:
- Downstream consumer of the slice file reader. Reads a 5x5x64 state one 25-bit slice at a time.
- Drives the reader's ld/line_number to fetch slices 1..64, captures each returned slice and computes its 5-bit column parity C[x][z].
- Buffers all 64 parities, then streams the theta column effect D[x][z] = C[x-1][z] ^ C[x+1][z-1] per slice over a valid/ready handshake.

Parameters:
- N, 25, slice width; fixed at 25 (5x5). Bit index i = 5*y + x.
- DEPTH, 64, slices per state; lane length z = 0..DEPTH-1.
- ZW, 6, width of the slice index and line_number.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a run when idle
- ld  out  1  load request to reader
- line_number  out  ZW  requested line, 1-based (= z+1)
- pin  in  N  slice from reader (reader's registered pout)
- out_valid  out  1  d_out/c_out/out_z valid
- out_ready  in  1  consumer accepts when high with out_valid
- d_out  out  5  D[x][out_z], bit x
- c_out  out  5  C[x][out_z], bit x
- out_z  out  ZW  slice index of current output
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last output is accepted

Behaviour:
- Reset: ld=0, line_number=0, out_valid=0, d_out=0, c_out=0, out_z=0, busy=0, done=0, state=IDLE, z=0. Parity buffer is not cleared; it is rewritten before any read in a run.
- Reset mid-operation: abort immediately to IDLE with the reset values above. No partial output is completed.
- IDLE: on start=1 set busy=1, z=0 and go to REQ. start is ignored in every other state.
- REQ, 1 cycle: ld=1 and line_number=z+1. Go to WAIT.
- WAIT, 1 cycle: ld=0. The reader updates pout on the REQ edge, so pin is valid this cycle. Go to CAP.
- CAP, 1 cycle:
  - C[x][z] = XOR over y=0..4 of pin[5*y+x]; write it to buffer entry z.
  - If z==DEPTH-1, set z=0 and go to EMIT. Otherwise z=z+1 and go to REQ.
  - Fetch cost is 3 cycles per slice, 192 cycles for the fetch phase.
- EMIT:
  - out_valid=1, out_z=z, c_out=C[*][z].
  - d_out[x] = C[(x+4)%5][z] ^ C[(x+1)%5][(z+DEPTH-1)%DEPTH].
  - Outputs are registered and stay stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready: if z==DEPTH-1, drop out_valid and go to DONE. Otherwise z=z+1 and present the next slice on the following cycle, so one output per cycle under continuous ready.
- Wrap-around:
  - z=0 uses C[*][DEPTH-1] for its z-1 term.
  - The x index wraps mod 5, so x=0 uses x-1=4 and x=4 uses x+1=0.
- DONE, 1 cycle: done=1, busy=0, return to IDLE. A start in this cycle is ignored.
- A start asserted in the same cycle as a rst deassertion edge is honoured only if rst is low at that clock edge.
- line_number holds its last value while ld=0. The reader only acts on ld=1.

Test Plan:
- All 64 slices zero; start, out_ready=1 -> 64 outputs with d_out=0 and c_out=0, out_z 0..63 in order. done pulses once. busy high for exactly 192+64+1 cycles.
- Slice z=5 = 25'h0000001 (x=0,y=0), all others zero:
  - z=5: c_out=5'b00001, d_out=5'b00010.
  - z=6: d_out=5'b10000.
  - All other slices: 0.
- Wrap: slice z=63 = 25'h0000001, all others zero -> z=63 gives d_out=5'b00010; z=0 gives d_out=5'b10000.
- Parity cancel: slice z=10 = 25'h0000021 (bits 0 and 5, same x) -> c_out=0 and d_out=0 for every z.
- Backpressure: toggle out_ready randomly during EMIT -> no output dropped or duplicated, and values stay stable while stalled. Reference is a bench model of C/D over a random state.
- Reset during fetch (z=20) and during EMIT (z=30):
  - All outputs return to reset values immediately.
  - A new start runs a full, correct 64-slice pass.
  - A start pulsed while busy is ignored (run count unchanged).
